// File: rtl/ysyx_23060187_mem_arbiter.sv
// Shares the core's single memory port between IFU fetches and LSU loads/stores.
// Fixed LSU priority, one outstanding transaction, and a bounded wait that ends in an error response.
module ysyx_23060187_mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          ifu_valid,
    output logic          ifu_ready,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_rvalid,
    output logic [DW-1:0] ifu_rdata,
    output logic          ifu_err,

    input  logic          lsu_valid,
    output logic          lsu_ready,
    input  logic          lsu_wen,
    input  logic [AW-1:0] lsu_addr,
    input  logic [DW-1:0] lsu_wdata,
    input  logic [7:0]    lsu_wmask,
    output logic          lsu_rvalid,
    output logic [DW-1:0] lsu_rdata,
    output logic          lsu_err,

    output logic          mem_valid,
    input  logic          mem_ready,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,

    output logic [1:0]    owner
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_IFU = 2'b01,
        WAIT_LSU = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wen_q, wen_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [7:0]      wmask_q, wmask_d;

    logic            resp_valid;
    logic            resp_err;
    logic [DW-1:0]   resp_data;

    // State and captured request; reset abandons any outstanding transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    // Response of the current WAIT cycle: real data wins over a coincident timeout.
    always_comb begin
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_data  = '0;
        if (state_q != IDLE) begin
            if (mem_rvalid) begin
                resp_valid = 1'b1;
                resp_data  = mem_rdata;
            end else if (cnt_q == CNT_LAST) begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
            end
        end
    end

    // Grant, request forwarding and next-state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        mem_valid = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        ifu_ready = 1'b0;
        lsu_ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rst && lsu_valid) begin
                    mem_valid = 1'b1;
                    mem_wen   = lsu_wen;
                    mem_addr  = lsu_addr;
                    mem_wdata = lsu_wdata;
                    mem_wmask = lsu_wmask;
                    lsu_ready = mem_ready;
                    if (mem_ready) begin
                        state_d = WAIT_LSU;
                    end
                end else if (rst && ifu_valid) begin
                    mem_valid = 1'b1;
                    mem_addr  = ifu_addr;
                    ifu_ready = mem_ready;
                    if (mem_ready) begin
                        state_d = WAIT_IFU;
                    end
                end
                if (mem_valid && mem_ready) begin
                    cnt_d   = '0;
                    wen_d   = mem_wen;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wmask_d = mem_wmask;
                end
            end
            WAIT_IFU, WAIT_LSU: begin
                mem_wen   = wen_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_wmask = wmask_q;
                if (resp_valid) begin
                    state_d = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Route the response to the owning master only; everything else stays zero.
    always_comb begin
        ifu_rvalid = 1'b0;
        ifu_err    = 1'b0;
        ifu_rdata  = '0;
        lsu_rvalid = 1'b0;
        lsu_err    = 1'b0;
        lsu_rdata  = '0;
        if (state_q == WAIT_IFU) begin
            ifu_rvalid = resp_valid;
            ifu_err    = resp_err;
            ifu_rdata  = resp_data;
        end else if (state_q == WAIT_LSU) begin
            lsu_rvalid = resp_valid;
            lsu_err    = resp_err;
            lsu_rdata  = resp_data;
        end
    end

    assign owner = 2'(state_q);

endmodule

// File: tb/tb_ysyx_23060187_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter, built with a short timeout of 4 cycles.
module tb_ysyx_23060187_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_valid, ifu_ready, ifu_rvalid, ifu_err;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_valid, lsu_ready, lsu_wen, lsu_rvalid, lsu_err;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [7:0]    lsu_wmask;
    logic          mem_valid, mem_ready, mem_wen, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [7:0]    mem_wmask;
    logic [1:0]    owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_23060187_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_addr(ifu_addr),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .owner(owner)
    );

    // Step to the next falling edge; inputs are then driven and outputs checked 1ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ifu_valid = 0; ifu_addr = '0;
        lsu_valid = 0; lsu_wen = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        #1;
        if (owner !== 2'b00) begin errors++; $display("FAIL reset_owner got %b exp 00", owner); end checks++;
        if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %b exp 0", mem_valid); end checks++;
        if ({ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid, ifu_err, lsu_err} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 000000", {ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid, ifu_err, lsu_err});
        end checks++;
        if ({ifu_rdata, lsu_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", {ifu_rdata, lsu_rdata}); end checks++;
        next_cycle(); next_cycle();
        rst = 1;
        next_cycle();
    endtask

    task automatic test_ifu_read();
        idle_inputs();
        ifu_valid = 1; ifu_addr = 32'h8000_0000; mem_ready = 1;
        #1;
        if (mem_valid !== 1'b1) begin errors++; $display("FAIL ifu_mem_valid got %b exp 1", mem_valid); end checks++;
        if (mem_addr !== 32'h8000_0000) begin errors++; $display("FAIL ifu_mem_addr got %h exp 80000000", mem_addr); end checks++;
        if ({mem_wen, mem_wdata, mem_wmask} !== 41'h0) begin errors++; $display("FAIL ifu_mem_wfields got %h exp 0", {mem_wen, mem_wdata, mem_wmask}); end checks++;
        if ({ifu_ready, lsu_ready} !== 2'b10) begin errors++; $display("FAIL ifu_ready_accept got %b exp 10", {ifu_ready, lsu_ready}); end checks++;
        next_cycle();
        idle_inputs();
        mem_rvalid = 1; mem_rdata = 32'h0000_0413;
        #1;
        if (owner !== 2'b01) begin errors++; $display("FAIL ifu_owner got %b exp 01", owner); end checks++;
        if ({ifu_rvalid, ifu_err} !== 2'b10) begin errors++; $display("FAIL ifu_resp_flags got %b exp 10", {ifu_rvalid, ifu_err}); end checks++;
        if (ifu_rdata !== 32'h0000_0413) begin errors++; $display("FAIL ifu_rdata got %h exp 00000413", ifu_rdata); end checks++;
        if ({lsu_rvalid, lsu_err, lsu_rdata, lsu_ready} !== 35'h0) begin errors++; $display("FAIL ifu_lsu_quiet got %h exp 0", {lsu_rvalid, lsu_err, lsu_rdata, lsu_ready}); end checks++;
        if (mem_valid !== 1'b0) begin errors++; $display("FAIL ifu_wait_mem_valid got %b exp 0", mem_valid); end checks++;
        next_cycle();
        idle_inputs();
        #1;
        if (owner !== 2'b00) begin errors++; $display("FAIL ifu_back_idle got %b exp 00", owner); end checks++;
        next_cycle();
    endtask

    task automatic test_contention();
        idle_inputs();
        ifu_valid = 1; ifu_addr = 32'h8000_0004;
        lsu_valid = 1; lsu_addr = 32'h8000_1000; mem_ready = 1;
        #1;
        if ({lsu_ready, ifu_ready} !== 2'b10) begin errors++; $display("FAIL cont_grant got %b exp 10", {lsu_ready, ifu_ready}); end checks++;
        if (mem_addr !== 32'h8000_1000) begin errors++; $display("FAIL cont_mem_addr got %h exp 80001000", mem_addr); end checks++;
        next_cycle();
        lsu_valid = 0; mem_rvalid = 1; mem_rdata = 32'hdead_beef;
        #1;
        if (owner !== 2'b10) begin errors++; $display("FAIL cont_owner_lsu got %b exp 10", owner); end checks++;
        if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'hdead_beef) begin errors++; $display("FAIL cont_lsu_resp got %b/%h exp 1/deadbeef", lsu_rvalid, lsu_rdata); end checks++;
        if ({ifu_ready, ifu_rvalid, mem_valid} !== 3'b000) begin errors++; $display("FAIL cont_no_issue got %b exp 000", {ifu_ready, ifu_rvalid, mem_valid}); end checks++;
        next_cycle();
        mem_rvalid = 0; mem_rdata = '0;
        #1;
        if (ifu_ready !== 1'b1 || mem_addr !== 32'h8000_0004) begin errors++; $display("FAIL cont_ifu_accept got %b/%h exp 1/80000004", ifu_ready, mem_addr); end checks++;
        next_cycle();
        ifu_valid = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
        #1;
        if (owner !== 2'b01) begin errors++; $display("FAIL cont_owner_ifu got %b exp 01", owner); end checks++;
        if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0000_0013) begin errors++; $display("FAIL cont_ifu_resp got %b/%h exp 1/00000013", ifu_rvalid, ifu_rdata); end checks++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_lsu_write();
        idle_inputs();
        lsu_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_2000;
        lsu_wdata = 32'h1234_5678; lsu_wmask = 8'h0f; mem_ready = 1;
        #1;
        if ({mem_valid, mem_wen} !== 2'b11) begin errors++; $display("FAIL wr_valid_wen got %b exp 11", {mem_valid, mem_wen}); end checks++;
        if (mem_addr !== 32'h8000_2000 || mem_wdata !== 32'h1234_5678 || mem_wmask !== 8'h0f) begin
            errors++; $display("FAIL wr_fields got %h/%h/%h exp 80002000/12345678/0f", mem_addr, mem_wdata, mem_wmask);
        end checks++;
        if (lsu_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got %b exp 1", lsu_ready); end checks++;
        next_cycle();
        idle_inputs();
        #1;
        if (lsu_rvalid !== 1'b0) begin errors++; $display("FAIL wr_early_resp got %b exp 0", lsu_rvalid); end checks++;
        next_cycle();
        mem_rvalid = 1;
        #1;
        if ({lsu_rvalid, lsu_err, ifu_rvalid} !== 3'b100) begin errors++; $display("FAIL wr_ack got %b exp 100", {lsu_rvalid, lsu_err, ifu_rvalid}); end checks++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_backpressure();
        idle_inputs();
        ifu_valid = 1; ifu_addr = 32'h8000_0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            if ({ifu_ready, mem_valid} !== 2'b01 || mem_addr !== 32'h8000_0010) begin
                errors++; $display("FAIL bp_hold_%0d got %b/%h exp 01/80000010", i, {ifu_ready, mem_valid}, mem_addr);
            end checks++;
            next_cycle();
        end
        mem_ready = 1;
        #1;
        if (ifu_ready !== 1'b1) begin errors++; $display("FAIL bp_accept got %b exp 1", ifu_ready); end checks++;
        next_cycle();
        idle_inputs();
        mem_rvalid = 1; mem_rdata = 32'h0000_0097;
        #1;
        if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0000_0097) begin errors++; $display("FAIL bp_resp got %b/%h exp 1/00000097", ifu_rvalid, ifu_rdata); end checks++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_timeout(input logic race);
        idle_inputs();
        lsu_valid = 1; lsu_addr = 32'h8000_3000; mem_ready = 1;
        next_cycle();
        idle_inputs();
        mem_rdata = 32'hffff_ffff;
        for (int i = 1; i < 4; i++) begin
            #1;
            if (lsu_rvalid !== 1'b0) begin errors++; $display("FAIL to_early_%0d got %b exp 0", i, lsu_rvalid); end checks++;
            next_cycle();
        end
        mem_rvalid = race;
        #1;
        if (race) begin
            if ({lsu_rvalid, lsu_err} !== 2'b10 || lsu_rdata !== 32'hffff_ffff) begin
                errors++; $display("FAIL to_race got %b/%h exp 10/ffffffff", {lsu_rvalid, lsu_err}, lsu_rdata);
            end checks++;
        end else begin
            if ({lsu_rvalid, lsu_err} !== 2'b11 || lsu_rdata !== 32'h0) begin
                errors++; $display("FAIL to_err got %b/%h exp 11/00000000", {lsu_rvalid, lsu_err}, lsu_rdata);
            end checks++;
        end
        next_cycle();
        mem_rvalid = 1;
        #1;
        if ({owner, lsu_rvalid, ifu_rvalid, lsu_rdata} !== 36'h0) begin
            errors++; $display("FAIL to_stray got %h exp 0", {owner, lsu_rvalid, ifu_rvalid, lsu_rdata});
        end checks++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_wait();
        idle_inputs();
        ifu_valid = 1; ifu_addr = 32'h8000_0020; mem_ready = 1;
        next_cycle();
        idle_inputs();
        #1;
        if (owner !== 2'b01) begin errors++; $display("FAIL rw_owner_before got %b exp 01", owner); end checks++;
        rst = 0;
        mem_rvalid = 1; mem_rdata = 32'h5555_aaaa;
        #1;
        if ({owner, ifu_rvalid, lsu_rvalid, ifu_err} !== 5'b0 || ifu_rdata !== 32'h0) begin
            errors++; $display("FAIL rw_in_reset got %b/%h exp 00000/00000000", {owner, ifu_rvalid, lsu_rvalid, ifu_err}, ifu_rdata);
        end checks++;
        next_cycle();
        rst = 1;
        #1;
        if ({ifu_rvalid, lsu_rvalid} !== 2'b00) begin errors++; $display("FAIL rw_stray got %b exp 00", {ifu_rvalid, lsu_rvalid}); end checks++;
        next_cycle();
        idle_inputs();
        ifu_valid = 1; ifu_addr = 32'h8000_0024; mem_ready = 1;
        #1;
        if (ifu_ready !== 1'b1 || mem_addr !== 32'h8000_0024) begin errors++; $display("FAIL rw_new_accept got %b/%h exp 1/80000024", ifu_ready, mem_addr); end checks++;
        next_cycle();
        idle_inputs();
        mem_rvalid = 1; mem_rdata = 32'h0000_0117;
        #1;
        if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0000_0117) begin errors++; $display("FAIL rw_new_resp got %b/%h exp 1/00000117", ifu_rvalid, ifu_rdata); end checks++;
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_contention();
        test_lsu_write();
        test_backpressure();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
